// File: rtl/irq_controller_if.sv
// ============================================================================
// Module   : irq_controller_if
// Brief    : CPU-side bundle of the interrupt controller (lines, mask, req/ack).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface irq_controller_if #(
  parameter int N_IRQ     = 4,
  parameter int VEC_WIDTH = 10
);
  logic [N_IRQ-1:0]     irq_in;
  logic                 mask_we;
  logic [N_IRQ-1:0]     mask_d;
  logic                 int_ack;
  logic                 iret;
  logic                 int_req;
  logic [VEC_WIDTH-1:0] vector;
  logic [N_IRQ-1:0]     active;
  logic [N_IRQ-1:0]     pending;
  logic [N_IRQ-1:0]     mask;

  modport master (
    output irq_in, mask_we, mask_d, int_ack, iret,
    input  int_req, vector, active, pending, mask
  );

  modport slave (
    input  irq_in, mask_we, mask_d, int_ack, iret,
    output int_req, vector, active, pending, mask
  );
endinterface

`default_nettype wire

// File: rtl/irq_controller.sv
// ============================================================================
// Module   : irq_controller
// Brief    : Edge-capturing, maskable, fixed-priority interrupt controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module irq_controller #(
  parameter int                   N_IRQ           = 4,
  parameter int                   VEC_WIDTH       = 10,
  parameter logic [VEC_WIDTH-1:0] VEC_BASE        = 10'h3F0,
  parameter int                   VEC_STRIDE_LOG2 = 2
) (
  input  wire logic           clk,
  input  wire logic           reset,
  irq_controller_if.slave     bus
);

  localparam int c_IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [N_IRQ-1:0]     r_irq_prev;
  logic [N_IRQ-1:0]     r_pending, w_pending_nxt;
  logic [N_IRQ-1:0]     r_mask, w_mask_nxt;
  logic [N_IRQ-1:0]     r_sel, w_sel_nxt;
  logic [N_IRQ-1:0]     r_active, w_active_nxt;
  logic [VEC_WIDTH-1:0] r_vector, w_vector_nxt;

  logic [N_IRQ-1:0]     w_rise;
  logic [N_IRQ-1:0]     w_clr;
  logic [N_IRQ-1:0]     w_enabled;
  logic [N_IRQ-1:0]     w_cand;
  logic [c_IDX_W-1:0]   w_idx;
  logic [VEC_WIDTH-1:0] w_vec_calc;

  assign w_rise    = bus.irq_in & ~r_irq_prev;
  assign w_enabled = r_pending & r_mask;
  // Two's-complement trick isolates the lowest set bit (line 0 wins).
  assign w_cand    = w_enabled & (~w_enabled + N_IRQ'(1));

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (w_cand[i]) w_idx = c_IDX_W'(i);
    end
  end

  assign w_vec_calc = VEC_BASE + (VEC_WIDTH'(w_idx) << VEC_STRIDE_LOG2);

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_active_nxt = r_active;
    w_vector_nxt = r_vector;
    w_clr        = '0;
    unique case (r_state)
      IDLE: begin
        if (|w_cand) begin
          w_sel_nxt    = w_cand;
          w_vector_nxt = w_vec_calc;
          w_state_nxt  = REQ;
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          w_clr        = r_sel;
          w_active_nxt = r_sel;
          w_state_nxt  = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.iret) begin
          w_active_nxt = '0;
          w_sel_nxt    = '0;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A fresh edge outranks the acknowledge-clear on the same bit.
  assign w_pending_nxt = w_rise | (r_pending & ~w_clr);
  assign w_mask_nxt    = bus.mask_we ? bus.mask_d : r_mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_mask     <= '0;
      r_sel      <= '0;
      r_active   <= '0;
      r_vector   <= VEC_BASE;
    end else begin
      r_state    <= w_state_nxt;
      r_irq_prev <= bus.irq_in;
      r_pending  <= w_pending_nxt;
      r_mask     <= w_mask_nxt;
      r_sel      <= w_sel_nxt;
      r_active   <= w_active_nxt;
      r_vector   <= w_vector_nxt;
    end
  end

  assign bus.int_req = (r_state == REQ);
  assign bus.vector  = r_vector;
  assign bus.active  = r_active;
  assign bus.pending = r_pending;
  assign bus.mask    = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// ============================================================================
// Module   : tb_irq_controller
// Brief    : Directed self-checking bench for irq_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_irq_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  irq_controller_if #(.N_IRQ(4), .VEC_WIDTH(10)) bus ();

  irq_controller #(
    .N_IRQ          (4),
    .VEC_WIDTH      (10),
    .VEC_BASE       (10'h3F0),
    .VEC_STRIDE_LOG2(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack_cycle();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic iret_cycle();
    bus.iret = 1'b1;
    tick();
    bus.iret = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b0;
    bus.irq_in  = '0;
    bus.mask_we = 1'b0;
    bus.mask_d  = '0;
    bus.int_ack = 1'b0;
    bus.iret    = 1'b0;
    tick();
    tick();
    check("rst_int_req", 32'(bus.int_req), 32'h0);
    check("rst_vector",  32'(bus.vector),  32'h3F0);
    check("rst_active",  32'(bus.active),  32'h0);
    check("rst_pending", 32'(bus.pending), 32'h0);
    check("rst_mask",    32'(bus.mask),    32'h0);
    reset = 1'b1;
    tick();

    bus.mask_we = 1'b1;
    bus.mask_d  = 4'b1111;
    tick();
    bus.mask_we = 1'b0;
    check("mask_write", 32'(bus.mask), 32'hF);

    // Single line 2: latency, ack, iret.
    bus.irq_in = 4'b0100;
    tick();
    check("t1_pending_e0", 32'(bus.pending), 32'h4);
    check("t1_req_e0",     32'(bus.int_req), 32'h0);
    tick();
    check("t1_req_e1",     32'(bus.int_req), 32'h1);
    check("t1_vector",     32'(bus.vector),  32'h3F8);
    ack_cycle();
    check("t1_active",     32'(bus.active),  32'h4);
    check("t1_pend_clr",   32'(bus.pending), 32'h0);
    check("t1_req_drop",   32'(bus.int_req), 32'h0);
    iret_cycle();
    check("t1_active_clr", 32'(bus.active),  32'h0);
    tick();
    check("t1_held_noreq", 32'(bus.int_req), 32'h0);
    bus.irq_in = '0;
    tick();

    // Simultaneous lines 1 and 3: priority order.
    bus.irq_in = 4'b1010;
    tick();
    check("t2_pending",    32'(bus.pending), 32'hA);
    tick();
    check("t2_req",        32'(bus.int_req), 32'h1);
    check("t2_vector1",    32'(bus.vector),  32'h3F4);
    ack_cycle();
    check("t2_pend_after", 32'(bus.pending), 32'h8);
    check("t2_active1",    32'(bus.active),  32'h2);
    iret_cycle();
    check("t2_idle_gap",   32'(bus.int_req), 32'h0);
    tick();
    check("t2_req3",       32'(bus.int_req), 32'h1);
    check("t2_vector3",    32'(bus.vector),  32'h3FC);
    ack_cycle();
    check("t2_active3",    32'(bus.active),  32'h8);
    iret_cycle();
    bus.irq_in = '0;
    tick();

    // Masked line 0, then unmask.
    bus.mask_we = 1'b1;
    bus.mask_d  = 4'b1110;
    tick();
    bus.mask_we = 1'b0;
    bus.irq_in  = 4'b0001;
    tick();
    check("t3_pending",    32'(bus.pending), 32'h1);
    tick();
    tick();
    check("t3_masked",     32'(bus.int_req), 32'h0);
    bus.mask_we = 1'b1;
    bus.mask_d  = 4'b1111;
    tick();
    bus.mask_we = 1'b0;
    check("t3_unmask_e0",  32'(bus.int_req), 32'h0);
    tick();
    check("t3_unmask_req", 32'(bus.int_req), 32'h1);
    check("t3_vector0",    32'(bus.vector),  32'h3F0);
    ack_cycle();
    iret_cycle();
    bus.irq_in = '0;
    tick();

    // No preemption while requesting line 2.
    bus.irq_in = 4'b0100;
    tick();
    tick();
    check("t4_vector2",    32'(bus.vector),  32'h3F8);
    bus.irq_in = 4'b0101;
    tick();
    check("t4_pending",    32'(bus.pending), 32'h5);
    check("t4_no_preempt", 32'(bus.vector),  32'h3F8);
    check("t4_req_held",   32'(bus.int_req), 32'h1);
    ack_cycle();
    check("t4_active2",    32'(bus.active),  32'h4);
    check("t4_pend0",      32'(bus.pending), 32'h1);
    iret_cycle();
    tick();
    check("t4_req0",       32'(bus.int_req), 32'h1);
    check("t4_vector0",    32'(bus.vector),  32'h3F0);
    ack_cycle();
    iret_cycle();
    bus.irq_in = '0;
    tick();

    // Re-edge on line 1 in the ack cycle: set wins over clear.
    bus.irq_in = 4'b0010;
    tick();
    bus.irq_in = '0;
    tick();
    check("t5_req",        32'(bus.int_req), 32'h1);
    bus.irq_in  = 4'b0010;
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.irq_in  = '0;
    check("t5_pend_kept",  32'(bus.pending), 32'h2);
    check("t5_active",     32'(bus.active),  32'h2);
    iret_cycle();
    check("t5_idle",       32'(bus.int_req), 32'h0);
    tick();
    check("t5_rereq",      32'(bus.int_req), 32'h1);
    check("t5_vector",     32'(bus.vector),  32'h3F4);
    ack_cycle();
    check("t5_pend_clr",   32'(bus.pending), 32'h0);
    iret_cycle();

    // Async reset while in service with line 3 pending.
    bus.irq_in = 4'b1001;
    tick();
    bus.irq_in = '0;
    tick();
    ack_cycle();
    check("t6_active0",    32'(bus.active),  32'h1);
    check("t6_pending3",   32'(bus.pending), 32'h8);
    reset = 1'b0;
    #1;
    check("t6_rst_req",    32'(bus.int_req), 32'h0);
    check("t6_rst_active", 32'(bus.active),  32'h0);
    check("t6_rst_pend",   32'(bus.pending), 32'h0);
    check("t6_rst_mask",   32'(bus.mask),    32'h0);
    check("t6_rst_vector", 32'(bus.vector),  32'h3F0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    check("t6_no_req",     32'(bus.int_req), 32'h0);
    check("t6_no_pend",    32'(bus.pending), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller for the single-cycle CPU. It captures rising edges on external interrupt lines into a pending register and masks them.
- It picks the highest-priority pending line using the lowest-set-bit rule (a & -a). It then hands the CPU a request plus a vector address with a req/ack handshake, and holds the line in service until the CPU signals return.
- It sits upstream of the PC next-address mux: the vector feeds the mux, and int_req/int_ack drive PC selection and PC save.

Parameters:
- N_IRQ, 4, number of interrupt lines; bit 0 is highest priority.
- VEC_WIDTH, 10, width of the vector output; matches the PC width.
- VEC_BASE, 10'h3F0, vector address of line 0.
- VEC_STRIDE_LOG2, 2, log2 of the spacing between vectors; vector = VEC_BASE + (idx << VEC_STRIDE_LOG2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- irq_in  input  N_IRQ  interrupt lines, already synchronous to clk; rising-edge sensitive.
- mask_we  input  1  mask write enable from the CPU.
- mask_d  input  N_IRQ  new mask value; a bit of 1 enables that line.
- int_ack  input  1  CPU accepts the request (one cycle, while int_req=1).
- iret  input  1  CPU returns from the handler (one cycle).
- int_req  output  1  interrupt request to the CPU.
- vector  output  VEC_WIDTH  handler address of the selected line.
- active  output  N_IRQ  one-hot line currently in service; 0 when none.
- pending  output  N_IRQ  pending register, readable by the CPU.
- mask  output  N_IRQ  current mask register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - pending, mask, irq_prev, sel, active = 0.
  - int_req = 0; vector = VEC_BASE.
- Edge capture:
  - rise = irq_in & ~irq_prev; irq_prev <= irq_in every cycle.
  - A line already high when reset is released counts as an edge.
- Pending update per bit, applied every cycle: pending[i] <= rise[i] | (pending[i] & ~clr[i]). clr is sel during the ack cycle, otherwise 0. Set wins when set and clear land on the same bit in the same cycle.
- Mask: mask <= mask_d when mask_we=1, in any state. It affects only arbitration in IDLE.
- Arbitration, combinational: cand = (pending & mask) & -(pending & mask), giving the lowest set bit. idx = binary index of cand.
- IDLE:
  - int_req=0.
  - If cand != 0: sel <= cand, vector <= VEC_BASE + (idx << VEC_STRIDE_LOG2), go to REQ.
  - int_ack and iret are ignored.
- REQ:
  - int_req=1; vector and sel are frozen. A newly pending higher-priority line does not preempt; masking sel does not withdraw the request.
  - On int_ack=1: clear pending&sel, active <= sel, go to SERVICE.
  - iret is ignored.
- SERVICE:
  - int_req=0; active holds. New edges still set pending.
  - On iret=1: active <= 0, sel <= 0, go to IDLE. int_ack is ignored. No nesting.
- Latency:
  - An irq_in edge sampled at clock edge E0 sets pending at E0.
  - state=REQ at E1, so int_req is high after E1 with no further delay.
  - After iret at edge En, a remaining pending line raises int_req after En+1. IDLE always lasts at least one cycle.
- A line held high generates one edge only; it must drop and rise again to re-pend.
- Reset asserted mid-operation (REQ or SERVICE) returns to the reset values immediately; pending lines are lost.
- Widths: the vector sum wraps modulo 2^VEC_WIDTH.

Test Plan:
- Reset, then irq_in=4'b0100, mask=4'b1111 → pending=4'b0100 after E0, int_req=1 and vector=10'h3F8 after E1. int_ack → active=4'b0100, pending=0, int_req=0. iret → active=0, IDLE.
- irq_in rises 4'b1010 in the same cycle with mask=4'b1111 → line 1 is selected, vector=10'h3F4. After ack and iret, line 3 is served next: vector=10'h3FC, with int_req rising one cycle after IDLE.
- mask=4'b1110 and irq_in[0] rises → pending=4'b0001 but int_req stays 0. Write mask=4'b1111 → int_req=1 and vector=10'h3F0 two cycles later.
- In REQ for line 2, line 0 rises → vector stays 10'h3F8 until ack. After iret, line 0 is served (vector=10'h3F0).
- irq_in[1] pulses again in the same cycle int_ack clears line 1 → pending[1] stays 1, and line 1 is re-requested after iret.
- Drive reset=0 while in SERVICE with pending=4'b1000 → int_req, active, pending and mask are all 0 immediately, state is IDLE, and no request follows after release while irq_in=0.
